// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shifter.
//   LEFT/RIGHT   : direction encodings for shift_direction
//   shift_op_e   : operation encodings for shift_op
//   state_e      : FSM state encodings for seq_shift_unit
package shift_pkg;

    localparam logic LEFT  = 1'b1;
    localparam logic RIGHT = 1'b0;

    typedef enum logic [1:0] {
        SHIFT_OP_LOGICAL = 2'b00,
        SHIFT_OP_ARITH   = 2'b01,
        SHIFT_OP_ROTATE  = 2'b10,
        SHIFT_OP_RSVD    = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StShift  = 2'b01,
        StFinish = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shift/rotate step.
//   w         in  WORD_SIZE  current working value
//   direction in  1          LEFT (1) or RIGHT (0)
//   op        in  shift_op_e logical / arithmetic / rotate / reserved
//   w_next    out WORD_SIZE  value after one 1-bit step
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 32
) (
    input  logic [WORD_SIZE-1:0] w,
    input  logic                 direction,
    input  shift_op_e            op,
    output logic [WORD_SIZE-1:0] w_next
);

    always_comb begin
        w_next = w;
        unique case (op)
            SHIFT_OP_LOGICAL: begin
                w_next = (direction == LEFT) ? {w[WORD_SIZE-2:0], 1'b0}
                                             : {1'b0, w[WORD_SIZE-1:1]};
            end
            SHIFT_OP_ARITH: begin
                // Arithmetic left is identical to logical left.
                w_next = (direction == LEFT) ? {w[WORD_SIZE-2:0], 1'b0}
                                             : {w[WORD_SIZE-1], w[WORD_SIZE-1:1]};
            end
            SHIFT_OP_ROTATE: begin
                w_next = (direction == LEFT) ? {w[WORD_SIZE-2:0], w[WORD_SIZE-1]}
                                             : {w[0], w[WORD_SIZE-1:1]};
            end
            SHIFT_OP_RSVD: begin
                // Reserved op walks through the full latency without changing w.
                w_next = w;
            end
            default: w_next = w;
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: performs an N-position shift/rotate as N single-bit steps,
// one per clock, with a start/busy/done handshake.
//   clk             in  1          rising-edge clock
//   reset           in  1          synchronous, active-high; aborts any operation
//   start           in  1          request, sampled only in idle
//   shift_direction in  1          1 = left, 0 = right
//   shift_op        in  2          00 logical, 01 arithmetic, 10 rotate, 11 reserved
//   shift_amount    in  AMT_WIDTH  number of positions
//   data_1          in  WORD_SIZE  operand
//   busy            out 1          high while stepping
//   done            out 1          one-cycle pulse with a valid shifter_out
//   shifter_out     out WORD_SIZE  result, held until the next completion
module seq_shift_unit
    import shift_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned AMT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 shift_direction,
    input  logic [1:0]           shift_op,
    input  logic [AMT_WIDTH-1:0] shift_amount,
    input  logic [WORD_SIZE-1:0] data_1,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] shifter_out
);

    state_e                 state_q, state_d;
    logic [AMT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [WORD_SIZE-1:0]   w_q, w_d;
    logic                   dir_q, dir_d;
    shift_op_e              op_q, op_d;
    logic [WORD_SIZE-1:0]   out_q, out_d;
    logic [WORD_SIZE-1:0]   w_step;

    shift_step #(
        .WORD_SIZE (WORD_SIZE)
    ) u_shift_step (
        .w         (w_q),
        .direction (dir_q),
        .op        (op_q),
        .w_next    (w_step)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        dir_d   = dir_q;
        op_d    = op_q;
        out_d   = out_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    w_d     = data_1;
                    dir_d   = shift_direction;
                    op_d    = shift_op_e'(shift_op);
                    cnt_d   = shift_amount;
                    state_d = (shift_amount != '0) ? StShift : StFinish;
                end
            end
            StShift: begin
                w_d   = w_step;
                cnt_d = cnt_q - AMT_WIDTH'(1);
                if (cnt_q == AMT_WIDTH'(1)) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                out_d   = w_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            w_q     <= '0;
            dir_q   <= RIGHT;
            op_q    <= SHIFT_OP_LOGICAL;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            dir_q   <= dir_d;
            op_q    <= op_d;
            out_q   <= out_d;
        end
    end

    assign busy = (state_q == StShift);
    assign done = (state_q == StFinish);
    // Present the result during the done cycle; out_q holds it afterwards.
    assign shifter_out = done ? w_q : out_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
module tb_seq_shift_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        shift_direction;
    logic [1:0]  shift_op;
    logic [4:0]  shift_amount;
    logic [31:0] data_1;
    logic        busy;
    logic        done;
    logic [31:0] shifter_out;

    int total = 0;
    int bad   = 0;

    seq_shift_unit #(
        .WORD_SIZE (32),
        .AMT_WIDTH (5)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .shift_direction (shift_direction),
        .shift_op        (shift_op),
        .shift_amount    (shift_amount),
        .data_1          (data_1),
        .busy            (busy),
        .done            (done),
        .shifter_out     (shifter_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts one op from idle, scrambles the inputs after acceptance, then checks
    // busy, latency, result and hold. Returns in idle, ready for a back-to-back start.
    task automatic run_op(input string tag, input logic dir, input logic [1:0] op,
                          input logic [4:0] amt, input logic [31:0] data,
                          input logic [31:0] exp);
        int lat;
        shift_direction = dir;
        shift_op        = op;
        shift_amount    = amt;
        data_1          = data;
        start           = 1'b1;
        tick();
        start           = 1'b0;
        shift_direction = ~dir;
        shift_op        = ~op;
        shift_amount    = ~amt;
        data_1          = ~data;
        lat = 1;
        if (amt != 5'd0) check_int({tag, "_busy"}, int'(busy), 1);
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check_int({tag, "_latency"}, lat, int'(amt) + 1);
        check_int({tag, "_busy_at_done"}, int'(busy), 0);
        check32({tag, "_result"}, shifter_out, exp);
        tick();
        check_int({tag, "_done_pulse"}, int'(done), 0);
        check32({tag, "_hold"}, shifter_out, exp);
    endtask

    initial begin
        int seen;
        int ndone;
        int first;
        logic [31:0] cap;

        reset = 1'b1;
        start = 1'b1;
        shift_direction = 1'b1;
        shift_op = 2'b00;
        shift_amount = 5'd3;
        data_1 = 32'hFFFF_FFFF;

        // Reset held with start high for two edges.
        tick();
        tick();
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_done", int'(done), 0);
        check32("rst_out", shifter_out, 32'h0);
        reset = 1'b0;
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (busy === 1'b1 || done === 1'b1) seen++;
        end
        check_int("rst_no_op", seen, 0);

        run_op("lsl4", 1'b1, 2'b00, 5'd4, 32'h0000_00F1, 32'h0000_0F10);
        run_op("asr4", 1'b0, 2'b01, 5'd4, 32'h8000_0010, 32'hF800_0001);
        run_op("lsr4", 1'b0, 2'b00, 5'd4, 32'h8000_0010, 32'h0800_0001);
        run_op("ror1", 1'b0, 2'b10, 5'd1, 32'h0000_0003, 32'h8000_0001);
        run_op("rol31", 1'b1, 2'b10, 5'd31, 32'h8000_0000, 32'h4000_0000);
        run_op("lsl31", 1'b1, 2'b00, 5'd31, 32'h0000_0003, 32'h8000_0000);
        run_op("rsvd3", 1'b1, 2'b11, 5'd3, 32'hA5A5_0000, 32'hA5A5_0000);
        // Amount 0 followed immediately by another op.
        run_op("amt0", 1'b1, 2'b00, 5'd0, 32'h1234_5678, 32'h1234_5678);
        run_op("b2b_asl", 1'b1, 2'b01, 5'd2, 32'hC000_0001, 32'h0000_0004);

        // Start issued mid-shift must be ignored.
        shift_direction = 1'b1;
        shift_op = 2'b00;
        shift_amount = 5'd8;
        data_1 = 32'h0000_0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        first = 0;
        cap = 32'h0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) begin
                start = 1'b1;
                shift_amount = 5'd2;
                data_1 = 32'hDEAD_BEEF;
            end
            if (i == 4) start = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                if (first == 0) begin
                    first = i;
                    cap = shifter_out;
                end
            end
            tick();
        end
        check_int("mid_start_ndone", ndone, 1);
        check_int("mid_start_latency", first, 9);
        check32("mid_start_result", cap, 32'h0000_0100);

        // Reset at the seventh edge after acceptance of a 20-step op.
        shift_direction = 1'b0;
        shift_op = 2'b00;
        shift_amount = 5'd20;
        data_1 = 32'hFFFF_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_int("abort_busy", int'(busy), 0);
        check_int("abort_done", int'(done), 0);
        check32("abort_out", shifter_out, 32'h0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            tick();
        end
        check_int("abort_no_done", seen, 0);
        run_op("after_abort", 1'b0, 2'b00, 5'd16, 32'hABCD_0000, 32'h0000_ABCD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
